// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-ported data memory between a scalar unit (port 0) and
// a vector unit (port 1). At most one transaction is issued per cycle. A
// lone requester is granted at once. When both request, round-robin picks
// the port that was not granted most recently. Reads return one cycle
// after the grant. The rvalid of the issuing port marks the data on the
// shared rdata bus.
//
// Ports
//   clk                      rising-edge clock
//   reset                    asynchronous, active-low reset
//   req0/req1                requests (0 = scalar, 1 = vector)
//   we0/we1                  1 = write, 0 = read
//   addr0/addr1              word addresses
//   be0/be1                  write byte enables
//   wdata0/wdata1            write data
//   gnt0/gnt1                combinational accept, issued to dmem this cycle
//   rvalid0/rvalid1          registered read-data-valid per port
//   rdata                    read data (mem_q passed through)
//   mem_address/byteena/data dmem request bus, zero when idle
//   mem_rden/mem_wren        dmem read / write enables
//   mem_q                    dmem read data, one cycle after the read
module dmem_arbiter #(
  parameter int WIDTH_V = 256,
  parameter int ADDR_W  = 14,
  parameter int BE_W    = WIDTH_V / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [ADDR_W-1:0]  addr0,
  input  logic [ADDR_W-1:0]  addr1,
  input  logic [BE_W-1:0]    be0,
  input  logic [BE_W-1:0]    be1,
  input  logic [WIDTH_V-1:0] wdata0,
  input  logic [WIDTH_V-1:0] wdata1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               rvalid0,
  output logic               rvalid1,
  output logic [WIDTH_V-1:0] rdata,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BE_W-1:0]    mem_byteena,
  output logic [WIDTH_V-1:0] mem_data,
  output logic               mem_rden,
  output logic               mem_wren,
  input  logic [WIDTH_V-1:0] mem_q
);

  // last_gnt_q = 1 means port 1 was granted most recently, so port 0 wins
  // the next contended cycle.
  logic last_gnt_q, last_gnt_d;
  logic pend_valid_q, pend_valid_d;
  logic pend_owner_q, pend_owner_d;

  logic gnt0_s, gnt1_s;

  // Grant selection. The grants are forced low while reset is held, so
  // nothing reaches dmem while the block is in reset.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!reset) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      case ({req1, req0})
        2'b01: gnt0_s = 1'b1;
        2'b10: gnt1_s = 1'b1;
        2'b11: begin
          if (last_gnt_q) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end
  end

  // dmem request bus: route the winner, or drive all zeros when idle.
  // Reads use full byte enables and zero write data.
  always_comb begin
    mem_address = {ADDR_W{1'b0}};
    mem_byteena = {BE_W{1'b0}};
    mem_data    = {WIDTH_V{1'b0}};
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    case ({gnt1_s, gnt0_s})
      2'b01: begin
        mem_address = addr0;
        if (we0) begin
          mem_wren    = 1'b1;
          mem_byteena = be0;
          mem_data    = wdata0;
        end else begin
          mem_rden    = 1'b1;
          mem_byteena = {BE_W{1'b1}};
        end
      end
      2'b10: begin
        mem_address = addr1;
        if (we1) begin
          mem_wren    = 1'b1;
          mem_byteena = be1;
          mem_data    = wdata1;
        end else begin
          mem_rden    = 1'b1;
          mem_byteena = {BE_W{1'b1}};
        end
      end
      default: begin
        mem_address = {ADDR_W{1'b0}};
        mem_byteena = {BE_W{1'b0}};
        mem_data    = {WIDTH_V{1'b0}};
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
      end
    endcase
  end

  // Next state: remember the last winner and which port owns the read now
  // in flight. pend_valid is high only for the cycle after a granted read.
  always_comb begin
    last_gnt_d   = last_gnt_q;
    pend_valid_d = 1'b0;
    pend_owner_d = pend_owner_q;
    if (gnt0_s) begin
      last_gnt_d   = 1'b0;
      pend_valid_d = ~we0;
      pend_owner_d = 1'b0;
    end else if (gnt1_s) begin
      last_gnt_d   = 1'b1;
      pend_valid_d = ~we1;
      pend_owner_d = 1'b1;
    end else begin
      last_gnt_d   = last_gnt_q;
      pend_valid_d = 1'b0;
      pend_owner_d = pend_owner_q;
    end
  end

  // Arbitration and read-tracking state. Asynchronous reset drops a pending
  // rvalid immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt_q   <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_owner_q <= 1'b0;
    end else begin
      last_gnt_q   <= last_gnt_d;
      pend_valid_q <= pend_valid_d;
      pend_owner_q <= pend_owner_d;
    end
  end

  assign gnt0    = gnt0_s;
  assign gnt1    = gnt1_s;
  assign rvalid0 = pend_valid_q & ~pend_owner_q;
  assign rvalid1 = pend_valid_q & pend_owner_q;
  assign rdata   = mem_q;

endmodule
